// File: rtl/booth_mul_seq_if.sv
// ---------------------------------------------------------------------------
// booth_mul_seq_if
// Operand/result handshake bundle between the Booth command sequencer and its
// neighbours.
//   op_valid / op_ready : operand pair offered by upstream, taken by sequencer
//   op_a                : multiplicand (unsigned)
//   op_b                : multiplier (two's-complement)
//   res_valid/res_ready : product offered by sequencer, taken by downstream
//   res_data            : product, truncated to PW bits
// The master modport is the traffic source/sink side (upstream + downstream),
// the slave modport is the sequencer itself.
// ---------------------------------------------------------------------------
interface booth_mul_seq_if #(
    parameter int DW = 10,
    parameter int PW = 24
);
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          res_valid;
    logic          res_ready;
    logic [PW-1:0] res_data;

    modport master (
        output op_valid,
        output op_a,
        output op_b,
        output res_ready,
        input  op_ready,
        input  res_valid,
        input  res_data
    );

    modport slave (
        input  op_valid,
        input  op_a,
        input  op_b,
        input  res_ready,
        output op_ready,
        output res_valid,
        output res_data
    );
endinterface

// File: rtl/booth_mul_seq.sv
// ---------------------------------------------------------------------------
// booth_mul_seq
// Command sequencer that feeds the 10x10 radix-4 Booth multiplier block.
// An operand pair is taken over a valid/ready handshake, written into the
// multiplier's two operand slots, the Booth operation is issued, and after a
// configurable settle time the registered product is captured and offered
// downstream over a second valid/ready handshake.
//
// Ports:
//   clock     : single clock, rising edge
//   reset     : synchronous, active-high
//   bus       : operand/result handshake bundle (slave side)
//   mul_wm    : multiplier mode, 00 write / 10 Booth / 01 idle-read
//   mul_addr  : multiplier operand slot, 0 = a, 1 = b
//   mul_in    : multiplier operand data
//   mul_prod  : registered product from the multiplier
//   busy      : high whenever the sequencer is not idle
//   op_count  : number of completed result handshakes, wraps at 2^16
//
// Parameters:
//   DW            : operand width, must match the multiplier data input
//   PW            : product width, must match the multiplier product output
//   SETTLE_CYCLES : cycles spent waiting after the Booth issue, 1..15
// ---------------------------------------------------------------------------
module booth_mul_seq #(
    parameter int DW            = 10,
    parameter int PW            = 24,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic           clock,
    input  logic           reset,
    booth_mul_seq_if.slave bus,
    output logic [1:0]     mul_wm,
    output logic [1:0]     mul_addr,
    output logic [DW-1:0]  mul_in,
    input  logic [PW-1:0]  mul_prod,
    output logic           busy,
    output logic [15:0]    op_count
);

    // Multiplier mode encodings.
    localparam logic [1:0] WM_WRITE = 2'b00;
    localparam logic [1:0] WM_BOOTH = 2'b10;
    localparam logic [1:0] WM_IDLE  = 2'b01;

    // Operand slot addresses inside the multiplier.
    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;

    // The counter is loaded with one less than the settle length so that it
    // reaches zero on the last SETTLE cycle.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        BOOTH,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [DW-1:0]   r_opA;
    logic [DW-1:0]   r_opB;
    logic [3:0]      r_settleCnt;
    logic            r_resValid;
    logic [PW-1:0]   r_resData;
    logic [15:0]     r_opCount;
    logic            w_opReady;
    logic            w_accept;
    logic            w_resFire;

    // Handshake qualifiers. The result handshake is only honoured in DONE,
    // which is also the only state where the result register is valid.
    assign w_accept  = bus.op_valid && w_opReady;
    assign w_resFire = (r_state == DONE) && r_resValid && bus.res_ready;

    // Next-state logic and the multiplier command decode. The multiplier
    // samples mode/address/data on the edge that ends each state, so these
    // outputs are pure decodes of the current state. Undriven address and
    // data are held at zero so the bus is quiet outside the load states.
    always_comb begin
        w_stateNext = r_state;
        w_opReady   = 1'b0;
        mul_wm      = WM_IDLE;
        mul_addr    = SLOT_A;
        mul_in      = '0;

        case (r_state)
            IDLE: begin
                w_opReady = 1'b1;
                if (bus.op_valid) begin
                    w_stateNext = LOAD_A;
                end
            end
            LOAD_A: begin
                mul_wm      = WM_WRITE;
                mul_addr    = SLOT_A;
                mul_in      = r_opA;
                w_stateNext = LOAD_B;
            end
            LOAD_B: begin
                mul_wm      = WM_WRITE;
                mul_addr    = SLOT_B;
                mul_in      = r_opB;
                w_stateNext = BOOTH;
            end
            BOOTH: begin
                mul_wm      = WM_BOOTH;
                w_stateNext = SETTLE;
            end
            SETTLE: begin
                if (r_settleCnt == 4'd0) begin
                    w_stateNext = CAPTURE;
                end
            end
            CAPTURE: begin
                w_stateNext = DONE;
            end
            DONE: begin
                if (w_resFire) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State register. Reset aborts any operation in flight; the multiplier's
    // own operand storage is left alone because every new operation rewrites
    // both slots before issuing the Booth command.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Operand latches. Operands are only captured on an accepted handshake,
    // so op_valid outside IDLE leaves the current pair untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_opA <= '0;
            r_opB <= '0;
        end else if (w_accept) begin
            r_opA <= bus.op_a;
            r_opB <= bus.op_b;
        end
    end

    // Settle counter. Loaded while the Booth command is on the bus and
    // counted down through SETTLE; it holds at zero once there so that a
    // settle length of one leaves SETTLE after a single cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_settleCnt <= 4'd0;
        end else if (r_state == BOOTH) begin
            r_settleCnt <= SETTLE_LOAD;
        end else if ((r_state == SETTLE) && (r_settleCnt != 4'd0)) begin
            r_settleCnt <= r_settleCnt - 4'd1;
        end
    end

    // Result register. The product is only copied in CAPTURE, after the
    // multiplier has had its settle time, so a partial product never reaches
    // res_data. While res_valid is high nothing else writes res_data.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_resValid <= 1'b0;
            r_resData  <= '0;
        end else if (r_state == CAPTURE) begin
            r_resValid <= 1'b1;
            r_resData  <= mul_prod;
        end else if (w_resFire) begin
            r_resValid <= 1'b0;
        end
    end

    // Completed-operation counter. Reset has priority, so a handshake on the
    // reset edge is not counted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_opCount <= 16'd0;
        end else if (w_resFire) begin
            r_opCount <= r_opCount + 16'd1;
        end
    end

    // Output wiring.
    assign bus.op_ready  = w_opReady;
    assign bus.res_valid = r_resValid;
    assign bus.res_data  = r_resData;
    assign busy          = (r_state != IDLE);
    assign op_count      = r_opCount;

endmodule

// File: tb/tb_booth_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_seq
// Bench for booth_mul_seq. Two sequencers are built, one with a settle length
// of 1 and one with 3, each attached to a behavioural model of the Booth
// multiplier (two operand slots, product registered one edge after the Booth
// command). Expected products are queued when operands are offered and
// compared when the sequencer presents its result.
// ---------------------------------------------------------------------------
module tb_booth_mul_seq;

    localparam int DW = 10;
    localparam int PW = 24;
    localparam int SETTLE0 = 1;
    localparam int SETTLE1 = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Stimulus, indexed by instance.
    logic          rst      [2];
    logic          opValid  [2];
    logic [DW-1:0] opA      [2];
    logic [DW-1:0] opB      [2];
    logic          resReady [2];
    logic [PW-1:0] mulProd  [2];

    // Raw DUT outputs.
    logic [1:0]    wm0, wm1, addr0, addr1;
    logic [DW-1:0] in0, in1;
    logic          busy0, busy1;
    logic [15:0]   cnt0, cnt1;

    // DUT outputs collected per instance.
    logic          sRdy  [2];
    logic          sRv   [2];
    logic [PW-1:0] sRd   [2];
    logic [1:0]    sWm   [2];
    logic [1:0]    sAddr [2];
    logic [DW-1:0] sIn   [2];
    logic          sBusy [2];
    logic [15:0]   sCnt  [2];

    booth_mul_seq_if #(.DW(DW), .PW(PW)) ifA ();
    booth_mul_seq_if #(.DW(DW), .PW(PW)) ifB ();

    assign ifA.op_valid  = opValid[0];
    assign ifA.op_a      = opA[0];
    assign ifA.op_b      = opB[0];
    assign ifA.res_ready = resReady[0];
    assign ifB.op_valid  = opValid[1];
    assign ifB.op_a      = opA[1];
    assign ifB.op_b      = opB[1];
    assign ifB.res_ready = resReady[1];

    booth_mul_seq #(.DW(DW), .PW(PW), .SETTLE_CYCLES(SETTLE0)) dut0 (
        .clock    (clock),
        .reset    (rst[0]),
        .bus      (ifA),
        .mul_wm   (wm0),
        .mul_addr (addr0),
        .mul_in   (in0),
        .mul_prod (mulProd[0]),
        .busy     (busy0),
        .op_count (cnt0)
    );

    booth_mul_seq #(.DW(DW), .PW(PW), .SETTLE_CYCLES(SETTLE1)) dut1 (
        .clock    (clock),
        .reset    (rst[1]),
        .bus      (ifB),
        .mul_wm   (wm1),
        .mul_addr (addr1),
        .mul_in   (in1),
        .mul_prod (mulProd[1]),
        .busy     (busy1),
        .op_count (cnt1)
    );

    always_comb begin
        sRdy[0]  = ifA.op_ready;   sRdy[1]  = ifB.op_ready;
        sRv[0]   = ifA.res_valid;  sRv[1]   = ifB.res_valid;
        sRd[0]   = ifA.res_data;   sRd[1]   = ifB.res_data;
        sWm[0]   = wm0;            sWm[1]   = wm1;
        sAddr[0] = addr0;          sAddr[1] = addr1;
        sIn[0]   = in0;            sIn[1]   = in1;
        sBusy[0] = busy0;          sBusy[1] = busy1;
        sCnt[0]  = cnt0;           sCnt[1]  = cnt1;
    end

    // Reference product: unsigned multiplicand times signed multiplier,
    // truncated to the product width.
    function automatic logic [PW-1:0] prodRef(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [PW-1:0] sa;
        logic signed [PW-1:0] sb;
        sa = {{(PW-DW){1'b0}}, a};
        sb = {{(PW-DW){b[DW-1]}}, b};
        return sa * sb;
    endfunction

    // Behavioural multiplier per instance: slots written in write mode, the
    // Booth command computes the product and it appears on mul_prod one edge
    // later. Slot contents survive a sequencer reset.
    logic [DW-1:0] slotA [2];
    logic [DW-1:0] slotB [2];
    logic [PW-1:0] pend  [2];
    logic          pendV [2];

    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (pendV[d]) mulProd[d] <= pend[d];
            pendV[d] <= 1'b0;
            if (sWm[d] == 2'b00) begin
                if (sAddr[d] == 2'd0) slotA[d] <= sIn[d];
                else if (sAddr[d] == 2'd1) slotB[d] <= sIn[d];
            end else if (sWm[d] == 2'b10) begin
                pend[d]  <= prodRef(slotA[d], slotB[d]);
                pendV[d] <= 1'b1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int expCount [2];
    int lastAccept [2];
    logic [PW-1:0] sb [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [1:0] expWm(input int k);
        if (k < 2) return 2'b00;
        else if (k == 2) return 2'b10;
        else return 2'b01;
    endfunction

    // Offer one operand pair to instance d and queue its expected product.
    // Returns just after the accept edge.
    task automatic applyStimulus(input int d, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [PW-1:0] req);
        int w;
        w = 0;
        @(negedge clock);
        while (!sRdy[d] && w < 50) begin
            @(negedge clock);
            w++;
        end
        checkOutput("op_ready_before_offer", 32'(sRdy[d]), 32'd1);
        opValid[d] = 1'b1;
        opA[d]     = a;
        opB[d]     = b;
        sb.push_back(req);
        @(posedge clock);
        #1;
        opValid[d] = 1'b0;
    endtask

    // Full operation: offer, follow the command sequence, check latency and
    // product, and complete the result handshake if res_ready is high.
    task automatic runOp(input int d, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [PW-1:0] req, input int settle, input bit b2b);
        int lat;
        int seqBad;
        logic [PW-1:0] want;
        applyStimulus(d, a, b, req);
        if (b2b) checkOutput("accept_spacing", 32'(cyc - lastAccept[d]), 32'(6 + settle));
        lastAccept[d] = cyc;
        lat    = 0;
        seqBad = 0;
        while (!sRv[d] && lat < 30) begin
            if (sWm[d] !== expWm(lat)) seqBad++;
            if (sBusy[d] !== 1'b1) seqBad++;
            if (sRdy[d] !== 1'b0) seqBad++;
            if (lat == 0 && {sAddr[d], sIn[d]} !== {2'd0, a}) seqBad++;
            if (lat == 1 && {sAddr[d], sIn[d]} !== {2'd1, b}) seqBad++;
            if (lat >= 2 && {sAddr[d], sIn[d]} !== {2'd0, {DW{1'b0}}}) seqBad++;
            @(posedge clock);
            #1;
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(4 + settle));
        checkOutput("command_sequence_errors", 32'(seqBad), 32'd0);
        if (sb.size() == 0) begin
            checkOutput("scoreboard_nonempty", 32'(sb.size()), 32'd1);
        end else begin
            want = sb.pop_front();
            checkOutput("res_data", 32'(sRd[d]), 32'(want));
        end
        if (resReady[d]) begin
            @(posedge clock);
            #1;
            expCount[d]++;
            checkOutput("op_count", 32'(sCnt[d]), 32'(expCount[d][15:0]));
            checkOutput("res_valid_after_handshake", 32'(sRv[d]), 32'd0);
            checkOutput("busy_after_handshake", 32'(sBusy[d]), 32'd0);
        end
    endtask

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [PW-1:0] p;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stableBad;
        int rvSeen;
        logic [DW-1:0] ra;
        logic [DW-1:0] rbv;

        vecs[0] = '{a: 10'd5,    b: 10'd3,     p: 24'h00000F};
        vecs[1] = '{a: 10'd1023, b: 10'd2,     p: 24'd2046};
        vecs[2] = '{a: 10'd5,    b: 10'h3FF,   p: 24'hFFFFFB};
        vecs[3] = '{a: 10'd0,    b: 10'h200,   p: 24'd0};
        vecs[4] = '{a: 10'd1023, b: 10'h200,   p: 24'hF80200};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; opValid[d] = 1'b0; opA[d] = '0; opB[d] = '0;
            resReady[d] = 1'b1; expCount[d] = 0; lastAccept[d] = 0;
        end

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_op_ready", 32'(sRdy[0]), 32'd1);
        checkOutput("reset_res_valid", 32'(sRv[0]), 32'd0);
        checkOutput("reset_res_data", 32'(sRd[0]), 32'd0);
        checkOutput("reset_mul_wm", 32'(sWm[0]), 32'd1);
        checkOutput("reset_mul_addr_in", 32'({sAddr[0], sIn[0]}), 32'd0);
        checkOutput("reset_busy", 32'(sBusy[0]), 32'd0);
        checkOutput("reset_op_count", 32'(sCnt[0]), 32'd0);
        checkOutput("reset_busy_s3", 32'(sBusy[1]), 32'd0);
        @(negedge clock);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Table-driven vectors, back-to-back after the first.
        for (int i = 0; i < 5; i++) begin
            runOp(0, vecs[i].a, vecs[i].b, vecs[i].p, SETTLE0, i > 0);
        end

        // Backpressure: result must hold and new operands must be ignored.
        resReady[0] = 1'b0;
        runOp(0, 10'd3, 10'd4, 24'd12, SETTLE0, 1'b0);
        stableBad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (k == 3) begin
                opValid[0] = 1'b1; opA[0] = 10'd7; opB[0] = 10'd1;
            end
            if (k == 4) opValid[0] = 1'b0;
            if (sRv[0] !== 1'b1 || sRd[0] !== 24'd12 || sRdy[0] !== 1'b0) stableBad++;
        end
        checkOutput("backpressure_stability_errors", 32'(stableBad), 32'd0);
        @(negedge clock);
        resReady[0] = 1'b1;
        @(posedge clock);
        #1;
        expCount[0]++;
        checkOutput("backpressure_op_count", 32'(sCnt[0]), 32'(expCount[0][15:0]));
        checkOutput("backpressure_res_valid_drop", 32'(sRv[0]), 32'd0);
        checkOutput("backpressure_idle_ready", 32'(sRdy[0]), 32'd1);
        @(posedge clock);
        #1;
        checkOutput("backpressure_ignored_op", 32'(sBusy[0]), 32'd0);

        // Reset on the same edge as the result handshake: reset wins.
        resReady[0] = 1'b0;
        runOp(0, 10'd2, 10'd2, 24'd4, SETTLE0, 1'b0);
        @(negedge clock);
        rst[0] = 1'b1;
        resReady[0] = 1'b1;
        @(posedge clock);
        #1;
        rst[0] = 1'b0;
        expCount[0] = 0;
        checkOutput("reset_vs_handshake_count", 32'(sCnt[0]), 32'd0);
        checkOutput("reset_vs_handshake_valid", 32'(sRv[0]), 32'd0);

        // Reset while the Booth command is on the bus.
        applyStimulus(0, 10'd100, 10'd100, 24'd10000);
        void'(sb.pop_back());
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        checkOutput("reached_booth", 32'(sWm[0]), 32'd2);
        @(negedge clock);
        rst[0] = 1'b1;
        @(posedge clock);
        #1;
        rst[0] = 1'b0;
        checkOutput("abort_busy", 32'(sBusy[0]), 32'd0);
        checkOutput("abort_res_valid", 32'(sRv[0]), 32'd0);
        checkOutput("abort_op_ready", 32'(sRdy[0]), 32'd1);
        checkOutput("abort_mul_wm", 32'(sWm[0]), 32'd1);
        rvSeen = 0;
        repeat (8) begin
            @(posedge clock);
            #1;
            if (sRv[0] !== 1'b0 || sBusy[0] !== 1'b0) rvSeen++;
        end
        checkOutput("abort_no_partial_result", 32'(rvSeen), 32'd0);
        runOp(0, 10'd6, 10'd7, 24'd42, SETTLE0, 1'b0);

        // Longer settle build: single op then back-to-back random pairs.
        runOp(1, 10'd9, 10'd9, 24'd81, SETTLE1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            ra  = 10'($urandom_range(0, 1023));
            rbv = 10'($urandom_range(0, 1023));
            runOp(1, ra, rbv, prodRef(ra, rbv), SETTLE1, 1'b1);
        end
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Upstream command sequencer for the 10x10 radix-4 Booth multiplier block.
- Accepts an operand pair over a valid/ready handshake and drives the multiplier's mode, address and data inputs through the fixed load/multiply sequence.
- Waits for the CLA adder tree result to be registered, captures the 24-bit product, and presents it downstream over a valid/ready handshake.

Parameters:
- DW, 10, operand width; must match the multiplier data input.
- PW, 24, product width; must match the multiplier product output.
- SETTLE_CYCLES, 1, cycles spent in SETTLE after the Booth issue cycle; legal range 1..15.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  operand pair available.
- op_ready  out  1  sequencer can accept an operand pair.
- op_a  in  DW  multiplicand; treated as unsigned.
- op_b  in  DW  multiplier; treated as two's-complement signed.
- res_valid  out  1  product available.
- res_ready  in  1  downstream accepts the product.
- res_data  out  PW  product, modulo 2^PW.
- mul_wm  out  2  mode to the multiplier: 00 write, 10 Booth, 01 idle/read.
- mul_addr  out  2  operand slot to the multiplier: 0 = a, 1 = b.
- mul_in  out  DW  operand data to the multiplier.
- mul_prod  in  PW  registered product from the multiplier.
- busy  out  1  high in every state except IDLE.
- op_count  out  16  count of completed result handshakes; wraps at 2^16.

Behaviour:
- States: IDLE, LOAD_A, LOAD_B, BOOTH, SETTLE, CAPTURE, DONE.
- mul_wm, mul_addr and mul_in are combinational decodes of the current state, so the multiplier samples them on the edge that ends that state.
- IDLE: op_ready = 1, mul_wm = 01. On op_valid && op_ready, latch op_a into a_q and op_b into b_q, then go to LOAD_A.
- LOAD_A: mul_wm = 00, mul_addr = 0, mul_in = a_q. Next state LOAD_B.
- LOAD_B: mul_wm = 00, mul_addr = 1, mul_in = b_q. Next state BOOTH.
- BOOTH: mul_wm = 10. Next state SETTLE; load the settle counter with SETTLE_CYCLES-1.
- SETTLE: mul_wm = 01. Decrement the counter each cycle; go to CAPTURE when it reaches 0. The multiplier updates mul_prod on the first SETTLE edge.
- CAPTURE: mul_wm = 01. On the edge, res_data <= mul_prod and res_valid <= 1. Next state DONE.
- DONE: hold res_valid and res_data stable until res_ready. On the handshake edge: res_valid <= 0, op_count += 1, go to IDLE.
- Latency: with SETTLE_CYCLES = 1, res_valid rises 5 edges after the accept edge. In general it is 4 + SETTLE_CYCLES edges.
- Back-to-back throughput: one result per 6 + SETTLE_CYCLES cycles. IDLE is always visited for 1 cycle; ready is not pre-asserted during DONE.
- op_ready is 0 outside IDLE. op_valid in any other state is ignored and the operands are not latched.
- res_valid can fall only on a handshake or on reset. res_data does not change while res_valid = 1.
- mul_addr = 0 and mul_in = 0 in all states that do not drive them.
- Reset values: state IDLE, op_ready 1 (combinational from IDLE), res_valid 0, res_data 0, mul_wm 01, mul_addr 0, mul_in 0, busy 0, op_count 0, a_q/b_q 0, settle counter 0.
- Reset mid-operation: abort immediately and return to IDLE next cycle. A partial product is never presented. Multiplier internal storage is not cleared; every new operation rewrites both slots.
- Reset and handshake on the same edge: reset wins and op_count is not incremented.

Test Plan:
- Reset, then op_a=5, op_b=3 with res_ready=1 -> res_valid high 5 cycles after accept; res_data=24'h00000F; op_count=1.
- op_a=10'd1023, op_b=10'd2 -> res_data=24'd2046; mul_wm sequence observed per cycle from accept: 00,00,10,01,01.
- op_a=5, op_b=10'h3FF (-1) -> res_data=24'hFFFFFB. Then op_a=0, op_b=10'h200 -> res_data=0.
- Backpressure: res_ready=0 for 10 cycles after res_valid -> res_valid and res_data stable and op_ready=0 throughout; op_valid pulsed with op_a=7 is ignored. Then res_ready=1 -> op_count increments once and IDLE is reached next cycle.
- Reset asserted during BOOTH -> next cycle state IDLE, res_valid=0, busy=0. A following op_a=6, op_b=7 -> res_data=24'd42.
- SETTLE_CYCLES=3 build: op_a=9, op_b=9 -> res_valid 7 cycles after accept, res_data=24'd81. 20 back-to-back random pairs match a_unsigned*b_signed mod 2^24.
